// File: rtl/mul_lzc_stage.sv
// Two-stage leading-zero count / normalization control ahead of the left shifter.
// Optional exponent-limited (subnormal) normalization: define MUL_LZC_EXP_CLAMP_EN.
module mul_lzc_stage #(
  parameter int WIDTH = 48,
  parameter int GROUP = 16,
  parameter int EW    = 10,
  localparam int AWIDTH = $clog2(WIDTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_data,
  input  logic [EW-1:0]     in_exp,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_data,
  output logic [AWIDTH-1:0] out_shift,
  output logic [EW-1:0]     out_exp,
  output logic              out_zero,
  output logic              out_denorm
);

  localparam int NG = WIDTH / GROUP;
  localparam int CW = $clog2(GROUP + 1);
  localparam int LW = $clog2(WIDTH + 1);
  localparam int XW = EW + LW;

  function automatic logic [CW-1:0] grp_lzc(input logic [GROUP-1:0] g);
    logic [CW-1:0] n;
    logic          found;
    n     = '0;
    found = 1'b0;
    for (int i = GROUP - 1; i >= 0; i--) begin
      if (!found) begin
        if (g[i]) found = 1'b1;
        else      n = n + CW'(1);
      end
    end
    return n;
  endfunction

`ifdef MUL_LZC_EXP_CLAMP_EN
  // Shift stops one short of the exponent so the result lands at exponent 0.
  function automatic logic [AWIDTH-1:0] clamp_shift(input logic [EW-1:0] e);
    return (e == '0) ? '0 : AWIDTH'(e - EW'(1));
  endfunction
`endif

  logic              vld_p1;
  logic [WIDTH-1:0]  data_p1;
  logic [EW-1:0]     exp_p1;
  logic [CW-1:0]     cnt_p1 [NG];
  logic [NG-1:0]     zero_p1;
  logic              s2_ready;

  assign s2_ready = ~out_valid | out_ready;
  assign in_ready = ~vld_p1 | s2_ready;

  // ---- S1: register payload and per-group counts ----
  always_ff @(posedge clk) begin
    if (!rst_n)        vld_p1 <= 1'b0;
    else if (in_ready) vld_p1 <= in_valid;
  end

  always_ff @(posedge clk) begin
    if (in_ready && in_valid) begin
      data_p1 <= in_data;
      exp_p1  <= in_exp;
      for (int g = 0; g < NG; g++) begin
        cnt_p1[g]  <= grp_lzc(in_data[WIDTH-1-g*GROUP -: GROUP]);
        zero_p1[g] <= (in_data[WIDTH-1-g*GROUP -: GROUP] == '0);
      end
    end
  end

  logic [LW-1:0]     lzc;
  logic              done;
  logic              all_zero;
  logic [AWIDTH-1:0] shift_c;
  logic [EW-1:0]     exp_c;
`ifdef MUL_LZC_EXP_CLAMP_EN
  logic              denorm_c;
`endif

  always_comb begin
    lzc      = '0;
    done     = 1'b0;
    all_zero = &zero_p1;
    for (int g = 0; g < NG; g++) begin
      if (!done) begin
        if (zero_p1[g]) lzc = lzc + LW'(GROUP);
        else begin
          lzc  = lzc + LW'(cnt_p1[g]);
          done = 1'b1;
        end
      end
    end
    shift_c = AWIDTH'(lzc);
    exp_c   = exp_p1 - EW'(lzc);
`ifdef MUL_LZC_EXP_CLAMP_EN
    denorm_c = 1'b0;
`endif
    if (all_zero) begin
      shift_c = '0;
      exp_c   = exp_p1;
    end
`ifdef MUL_LZC_EXP_CLAMP_EN
    else if (XW'(exp_p1) <= XW'(lzc)) begin
      shift_c  = clamp_shift(exp_p1);
      exp_c    = '0;
      denorm_c = 1'b1;
    end
`endif
  end

  // ---- S2: combine groups, register outputs ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_shift <= '0;
      out_exp   <= '0;
      out_zero  <= 1'b0;
    end else if (s2_ready) begin
      out_valid <= vld_p1;
      if (vld_p1) begin
        out_data  <= data_p1;
        out_shift <= shift_c;
        out_exp   <= exp_c;
        out_zero  <= all_zero;
      end
    end
  end

`ifdef MUL_LZC_EXP_CLAMP_EN
  always_ff @(posedge clk) begin
    if (!rst_n)                  out_denorm <= 1'b0;
    else if (s2_ready && vld_p1) out_denorm <= denorm_c;
  end
`else
  assign out_denorm = 1'b0;
`endif

endmodule

// File: tb/tb_mul_lzc_stage.sv
// Directed, table-driven bench for mul_lzc_stage (default parameters).
// Expected values follow MUL_LZC_EXP_CLAMP_EN when it is defined.
module tb_mul_lzc_stage;
  localparam int WIDTH = 48;
  localparam int EW    = 10;
  localparam int AW    = 6;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [EW-1:0]    in_exp;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [AW-1:0]    out_shift;
  logic [EW-1:0]    out_exp;
  logic             out_zero;
  logic             out_denorm;

  mul_lzc_stage dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_exp(in_exp),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_shift(out_shift), .out_exp(out_exp), .out_zero(out_zero), .out_denorm(out_denorm)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] data;
    logic [EW-1:0]    exp;
    logic [AW-1:0]    x_shift;
    logic [EW-1:0]    x_exp;
    logic             x_zero;
    logic             x_denorm;
  } vec_t;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_beat(input string tag, input vec_t v);
    chk({tag, "_valid"},  64'(out_valid),  64'd1);
    chk({tag, "_data"},   64'(out_data),   64'(v.data));
    chk({tag, "_shift"},  64'(out_shift),  64'(v.x_shift));
    chk({tag, "_exp"},    64'(out_exp),    64'(v.x_exp));
    chk({tag, "_zero"},   64'(out_zero),   64'(v.x_zero));
    chk({tag, "_denorm"}, 64'(out_denorm), 64'(v.x_denorm));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_valid"},  64'(out_valid),  64'd0);
    chk({tag, "_data"},   64'(out_data),   64'd0);
    chk({tag, "_shift"},  64'(out_shift),  64'd0);
    chk({tag, "_exp"},    64'(out_exp),    64'd0);
    chk({tag, "_zero"},   64'(out_zero),   64'd0);
    chk({tag, "_denorm"}, 64'(out_denorm), 64'd0);
  endtask

  vec_t tbl[10];
  vec_t bp[4];

  initial begin
    int acc, got, idx;
    vec_t rx[$];

    tbl[0] = '{48'h0000_0100_0000, 10'd100,  6'd23, 10'd77,  1'b0, 1'b0};
    tbl[1] = '{48'h8000_0000_0000, 10'd333,  6'd0,  10'd333, 1'b0, 1'b0};
    tbl[2] = '{48'h0000_0000_0001, 10'd200,  6'd47, 10'd153, 1'b0, 1'b0};
    tbl[3] = '{48'h0000_0000_0000, 10'd55,   6'd0,  10'd55,  1'b1, 1'b0};
    tbl[4] = '{48'h0000_FFFF_0000, 10'd40,   6'd16, 10'd24,  1'b0, 1'b0};
    tbl[5] = '{48'h0000_0000_FFFF, 10'd1000, 6'd32, 10'd968, 1'b0, 1'b0};
    tbl[9] = '{48'h0000_0000_0000, 10'd0,    6'd0,  10'd0,   1'b1, 1'b0};
`ifdef MUL_LZC_EXP_CLAMP_EN
    tbl[6] = '{48'h0000_0000_0001, 10'd10,   6'd9,  10'd0,   1'b0, 1'b1};
    tbl[7] = '{48'h0000_0000_0001, 10'd0,    6'd0,  10'd0,   1'b0, 1'b1};
    tbl[8] = '{48'h0000_0100_0000, 10'd23,   6'd22, 10'd0,   1'b0, 1'b1};
`else
    tbl[6] = '{48'h0000_0000_0001, 10'd10,   6'd47, 10'd987, 1'b0, 1'b0};
    tbl[7] = '{48'h0000_0000_0001, 10'd0,    6'd47, 10'd977, 1'b0, 1'b0};
    tbl[8] = '{48'h0000_0100_0000, 10'd23,   6'd23, 10'd0,   1'b0, 1'b0};
`endif
    bp[0] = '{48'h0000_0000_8000, 10'd300, 6'd32, 10'd268, 1'b0, 1'b0};
    bp[1] = '{48'h0001_0000_0000, 10'd20,  6'd15, 10'd5,   1'b0, 1'b0};
    bp[2] = '{48'h0400_0000_0000, 10'd6,   6'd5,  10'd1,   1'b0, 1'b0};
    bp[3] = '{48'h0000_0000_0003, 10'd500, 6'd46, 10'd454, 1'b0, 1'b0};

    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_exp = '0; out_ready = 1'b1;
    tick(); tick();
    chk_all_zero("reset");
    rst_n = 1'b1;
    #1;
    chk("reset_in_ready", 64'(in_ready), 64'd1);

    // Single beats: output valid after the second edge, not the first.
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; in_data = tbl[i].data; in_exp = tbl[i].exp;
      tick();
      in_valid = 1'b0; in_data = '0; in_exp = '0;
      chk($sformatf("v%0d_early", i), 64'(out_valid), 64'd0);
      tick();
      chk_beat($sformatf("v%0d", i), tbl[i]);
    end
    tick();
    chk("idle_valid", 64'(out_valid), 64'd0);

    // Back-pressure: only two beats fit while the output is stalled.
    out_ready = 1'b0; acc = 0;
    for (int c = 0; c < 6; c++) begin
      in_valid = (acc < 4); in_data = bp[acc % 4].data; in_exp = bp[acc % 4].exp;
      #3;
      if (in_valid && in_ready) acc++;
      tick();
      if (c >= 2) chk_beat($sformatf("bp_stall%0d", c), bp[0]);
    end
    chk("bp_accepts", 64'(acc), 64'd2);
    chk("bp_in_ready", 64'(in_ready), 64'd0);

    out_ready = 1'b1; got = 0;
    for (int c = 0; c < 20 && got < 4; c++) begin
      in_valid = (acc < 4); in_data = bp[acc % 4].data; in_exp = bp[acc % 4].exp;
      #3;
      if (out_valid && out_ready) begin
        rx.push_back('{out_data, 10'd0, out_shift, out_exp, out_zero, out_denorm});
        got++;
      end
      if (in_valid && in_ready) acc++;
      tick();
    end
    in_valid = 1'b0;
    chk("bp_received", 64'(got), 64'd4);
    for (int k = 0; k < got; k++) begin
      chk($sformatf("bp_order%0d_data", k),  64'(rx[k].data),    64'(bp[k].data));
      chk($sformatf("bp_order%0d_shift", k), 64'(rx[k].x_shift), 64'(bp[k].x_shift));
      chk($sformatf("bp_order%0d_exp", k),   64'(rx[k].x_exp),   64'(bp[k].x_exp));
    end
    chk("bp_drained", 64'(out_valid), 64'd0);

    // Back-to-back flow: beat per cycle, second beat valid right after the first.
    in_valid = 1'b1; in_data = tbl[0].data; in_exp = tbl[0].exp;
    tick();
    in_data = tbl[4].data; in_exp = tbl[4].exp;
    tick();
    in_valid = 1'b0;
    chk_beat("b2b0", tbl[0]);
    tick();
    chk_beat("b2b1", tbl[4]);
    tick();

    // Reset with both stages full: nothing stale may come out afterwards.
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = bp[0].data; in_exp = bp[0].exp;
    tick();
    in_data = bp[1].data; in_exp = bp[1].exp;
    tick();
    in_valid = 1'b0;
    chk("rst_full_in_ready", 64'(in_ready), 64'd0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk_all_zero("rst_mid");
    chk("rst_mid_in_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b1; idx = 0;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (out_valid) idx++;
    end
    chk("rst_no_stale", 64'(idx), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
